// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared types and helpers for the SPI slave core:
//   state_e         FSM encoding (IDLE / SHIFT)
//   SPI_DEFAULT_TX  word shifted out on a transmit underrun
//   cnt_w()         width of the in-word bit counter
//   level_w()       width of a FIFO occupancy count (0..depth inclusive)
// -----------------------------------------------------------------------------
package spi_slave_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int SPI_DEFAULT_TX = 'hFF;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_fifo
// Synchronous FIFO holding received SPI words, clocked by sclk.
// Ports:
//   i_clk        clock (sclk)
//   i_rst_n      asynchronous active-low reset, empties the FIFO
//   i_push       write request, i_push_data is the word
//   i_pop        read request; ignored when empty
//   o_pop_data   head entry
//   o_level      occupancy 0..DEPTH
//   o_full       level == DEPTH
//   o_empty      level == 0
// A push while full is accepted only when a pop happens on the same edge.
// -----------------------------------------------------------------------------
module spi_slave_rx_fifo
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic [DATA_WIDTH-1:0]     i_push_data,
    input  logic                      i_pop,
    output logic [DATA_WIDTH-1:0]     o_pop_data,
    output logic [level_w(DEPTH)-1:0] o_level,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int AW = cnt_w(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage carries no reset; only pointers and level are control state.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI mode-0 slave, MSB first, clocked entirely by sclk (free-running while
// ss_n is high, so transmit preload and RX drain proceed in idle).
// Ports:
//   sclk, reset (async, active-low)     clock / reset
//   ss_n, mosi, miso, miso_oe           SPI bus side
//   tx_data, tx_valid, tx_ready         transmit word from local producer
//   rx_data, rx_valid, rx_ready         received words to local consumer
//   rx_level                            RX FIFO occupancy
//   busy                                FSM in SHIFT
//   overrun, underrun, frame_abort      sticky flags, cleared by clr_flags
//   clr_flags                           clear request (a same-edge set wins)
// The edge that first sees ss_n low only moves IDLE->SHIFT; bit sampling
// starts on the following edge, with the word MSB already on miso.
// -----------------------------------------------------------------------------
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RX_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = DATA_WIDTH'(SPI_DEFAULT_TX)
) (
    input  logic                         sclk,
    input  logic                         reset,
    input  logic                         ss_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    input  logic [DATA_WIDTH-1:0]        tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [DATA_WIDTH-1:0]        rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [level_w(RX_DEPTH)-1:0] rx_level,
    output logic                         busy,
    output logic                         overrun,
    output logic                         underrun,
    output logic                         frame_abort,
    input  logic                         clr_flags
);

    localparam int             CW   = cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    state_e                r_state,     w_state_nxt;
    logic [CW-1:0]         r_bit_cnt,   w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift,  w_tx_shift_nxt;
    logic                  r_tx_loaded, w_tx_loaded_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift,  w_rx_shift_nxt;
    logic                  r_miso;
    logic                  r_overrun, r_underrun, r_abort;

    logic                  w_tx_ready;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_set_under;
    logic                  w_set_abort;
    logic                  w_set_over;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_tx_shift_nxt  = r_tx_shift;
        w_tx_loaded_nxt = r_tx_loaded;
        w_rx_shift_nxt  = r_rx_shift;
        w_tx_ready      = 1'b0;
        w_push          = 1'b0;
        w_push_data     = {r_rx_shift[DATA_WIDTH-2:0], mosi};
        w_set_under     = 1'b0;
        w_set_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_tx_loaded && tx_valid) begin
                    w_tx_ready      = 1'b1;
                    w_tx_shift_nxt  = tx_data;
                    w_tx_loaded_nxt = 1'b1;
                end else if (!r_tx_loaded && !ss_n) begin
                    // Frame starts with nothing preloaded: first word is the default.
                    w_tx_shift_nxt = DEFAULT_TX;
                    w_set_under    = 1'b1;
                end
                if (!ss_n) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                if (ss_n) begin
                    w_state_nxt     = IDLE;
                    w_tx_loaded_nxt = 1'b0;
                    w_bit_cnt_nxt   = '0;
                    if (r_bit_cnt != '0) begin
                        w_set_abort    = 1'b1;
                        w_tx_shift_nxt = DEFAULT_TX;
                    end
                end else begin
                    w_rx_shift_nxt = {r_rx_shift[DATA_WIDTH-2:0], mosi};
                    if (r_bit_cnt == LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_push        = 1'b1;
                        if (tx_valid) begin
                            w_tx_ready     = 1'b1;
                            w_tx_shift_nxt = tx_data;
                        end else begin
                            w_tx_shift_nxt = DEFAULT_TX;
                            w_set_under    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                        w_tx_shift_nxt = r_tx_shift << 1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // miso follows the next shift-register MSB so the bit the master samples
    // on edge k is already stable from edge k-1.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt   <= '0;
            r_tx_shift  <= DEFAULT_TX;
            r_tx_loaded <= 1'b0;
            r_rx_shift  <= '0;
            r_miso      <= DEFAULT_TX[DATA_WIDTH-1];
        end else begin
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_tx_loaded <= w_tx_loaded_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_miso      <= w_tx_shift_nxt[DATA_WIDTH-1];
        end
    end

    assign w_pop      = rx_valid && rx_ready;
    assign w_set_over = w_push && w_full && !w_pop;

    // Sticky flags: a set on the same edge as a clear takes priority.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_overrun  <= w_set_over  ? 1'b1 : (clr_flags ? 1'b0 : r_overrun);
            r_underrun <= w_set_under ? 1'b1 : (clr_flags ? 1'b0 : r_underrun);
            r_abort    <= w_set_abort ? 1'b1 : (clr_flags ? 1'b0 : r_abort);
        end
    end

    spi_slave_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk       (sclk),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (rx_data),
        .o_level     (rx_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // tx_ready is held low during reset even though IDLE would otherwise accept.
    assign tx_ready    = reset && w_tx_ready;
    assign miso        = r_miso;
    assign miso_oe     = (r_state == SHIFT);
    assign busy        = (r_state == SHIFT);
    assign rx_valid    = !w_empty;
    assign overrun     = r_overrun;
    assign underrun    = r_underrun;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;

    logic       sclk;
    logic       reset;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_level;
    logic       busy;
    logic       overrun;
    logic       underrun;
    logic       frame_abort;
    logic       clr_flags;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] act_miso[$];

    spi_slave_core #(
        .DATA_WIDTH (8),
        .RX_DEPTH   (4),
        .DEFAULT_TX (8'hFF)
    ) dut (
        .sclk        (sclk),
        .reset       (reset),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_level    (rx_level),
        .busy        (busy),
        .overrun     (overrun),
        .underrun    (underrun),
        .frame_abort (frame_abort),
        .clr_flags   (clr_flags)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: pops expected RX words whenever the consumer handshake
    // is about to fire, and pairs up completed master-side miso words.
    initial begin
        logic [7:0] e;
        logic [7:0] a;
        forever begin
            @(negedge sclk);
            #2;
            if (reset && rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e});
                end
            end
            while (act_miso.size() > 0) begin
                a = act_miso.pop_front();
                if (exp_miso.size() == 0) begin
                    chk("miso_unexpected", {24'd0, a}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_miso.pop_front();
                    chk("miso_word", {24'd0, a}, {24'd0, e});
                end
            end
        end
    end

    // Master: drive mosi on negedge, capture miso as the master would see it
    // at the following posedge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit ready_last);
        logic [7:0] mi;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge sclk);
            mosi      = mo[7-i];
            mi[7-i]   = miso;
            if (ready_last && (i == nbits - 1)) rx_ready = 1'b1;
        end
        if (nbits == 8) act_miso.push_back(mi);
    endtask

    task automatic sel();
        @(negedge sclk);
        ss_n = 1'b0;
    endtask

    task automatic desel();
        @(negedge sclk);
        ss_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic clear_flags();
        @(negedge sclk);
        clr_flags = 1'b1;
        @(negedge sclk);
        clr_flags = 1'b0;
    endtask

    task automatic preload(input logic [7:0] d);
        @(negedge sclk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge sclk);
        tx_valid = 1'b0;
    endtask

    logic [7:0] t2_words [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] t3_words [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] t5_words [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    initial begin
        reset     = 1'b0;
        ss_n      = 1'b1;
        mosi      = 1'b0;
        tx_data   = 8'hA5;
        tx_valid  = 1'b1;
        rx_ready  = 1'b1;
        clr_flags = 1'b0;

        // Reset state (tx_valid high to show tx_ready is held low in reset)
        idle(2);
        #1;
        chk("rst_miso", {31'd0, miso}, 32'd1);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_level", {29'd0, rx_level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {29'd0, overrun, underrun, frame_abort}, 32'd0);

        // 1: preload 0xA5, master sends 0x3C
        @(negedge sclk);
        reset = 1'b1;
        #1 chk("t1_tx_ready_idle", {31'd0, tx_ready}, 32'd1);
        @(negedge sclk);
        #1 chk("t1_tx_ready_loaded", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        exp_miso.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        sel();
        spi_bits(8'h3C, 8, 1'b0);
        #1 chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_rx_valid_early", {31'd0, rx_valid}, 32'd0);
        @(posedge sclk);
        #1 chk("t1_rx_valid_latency", {31'd0, rx_valid}, 32'd1);
        desel();
        @(negedge sclk);
        #1 chk("t1_underrun_after_empty_load", {31'd0, underrun}, 32'd1);
        chk("t1_idle_miso_oe", {31'd0, miso_oe}, 32'd0);

        // 2: three words with no tx data -> 0xFF each, underrun
        clear_flags();
        #1 chk("t2_underrun_cleared", {31'd0, underrun}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            exp_miso.push_back(8'hFF);
            exp_rx.push_back(t2_words[k]);
        end
        sel();
        for (int k = 0; k < 3; k++) spi_bits(t2_words[k], 8, 1'b0);
        desel();
        @(negedge sclk);
        #1 chk("t2_underrun_set", {31'd0, underrun}, 32'd1);
        clear_flags();
        #1 chk("t2_underrun_clr", {31'd0, underrun}, 32'd0);

        // 3: five words with consumer stalled -> 4 stored, 5th dropped
        @(negedge sclk);
        rx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_miso.push_back(8'hFF);
            if (k < 4) exp_rx.push_back(t3_words[k]);
        end
        sel();
        for (int k = 0; k < 5; k++) begin
            spi_bits(t3_words[k], 8, 1'b0);
            if (k == 3) begin
                @(posedge sclk);
                #1 chk("t3_full_level", {29'd0, rx_level}, 32'd4);
                chk("t3_full_no_overrun", {31'd0, overrun}, 32'd0);
            end
        end
        desel();
        @(negedge sclk);
        #1 chk("t3_level", {29'd0, rx_level}, 32'd4);
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        @(negedge sclk);
        rx_ready = 1'b1;
        idle(6);
        #1 chk("t3_drained_level", {29'd0, rx_level}, 32'd0);
        chk("t3_drained_valid", {31'd0, rx_valid}, 32'd0);
        clear_flags();
        #1 chk("t3_overrun_clr", {31'd0, overrun}, 32'd0);

        // 4: abort after 5 bits, then a clean 0x81 frame
        preload(8'h00);
        sel();
        spi_bits(8'hF0, 5, 1'b0);
        desel();
        @(negedge sclk);
        #1 chk("t4_abort", {31'd0, frame_abort}, 32'd1);
        chk("t4_no_push", {29'd0, rx_level}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_miso_default", {31'd0, miso}, 32'd1);
        chk("t4_no_underrun", {31'd0, underrun}, 32'd0);
        exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'h81);
        sel();
        spi_bits(8'h81, 8, 1'b0);
        desel();
        idle(3);
        #1 chk("t4_abort_sticky", {31'd0, frame_abort}, 32'd1);
        clear_flags();
        #1 chk("t4_abort_clr", {31'd0, frame_abort}, 32'd0);

        // 5: FIFO full, pop and push on the same edge
        @(negedge sclk);
        rx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_miso.push_back(8'hFF);
            exp_rx.push_back(t5_words[k]);
        end
        sel();
        for (int k = 0; k < 5; k++) spi_bits(t5_words[k], 8, (k == 4));
        @(posedge sclk);
        #1 chk("t5_level", {29'd0, rx_level}, 32'd4);
        chk("t5_no_overrun", {31'd0, overrun}, 32'd0);
        @(negedge sclk);
        rx_ready = 1'b0;
        ss_n     = 1'b1;
        @(negedge sclk);
        #1 chk("t5_level_hold", {29'd0, rx_level}, 32'd4);
        rx_ready = 1'b1;
        idle(6);
        #1 chk("t5_drained", {29'd0, rx_level}, 32'd0);

        // 6: async reset mid-word, then a clean 0x55 frame
        @(negedge sclk);
        rx_ready = 1'b0;
        exp_miso.push_back(8'hFF);
        sel();
        spi_bits(8'h12, 8, 1'b0);
        spi_bits(8'h55, 4, 1'b0);
        #1 chk("t6_pre_level", {29'd0, rx_level}, 32'd1);
        chk("t6_pre_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1 chk("t6_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("t6_rx_level", {29'd0, rx_level}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_flags", {29'd0, overrun, underrun, frame_abort}, 32'd0);
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge sclk);
        reset    = 1'b1;
        rx_ready = 1'b1;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge sclk);
        tx_valid = 1'b0;
        exp_miso.push_back(8'hC3);
        exp_rx.push_back(8'h55);
        sel();
        spi_bits(8'h55, 8, 1'b0);
        desel();
        idle(4);

        chk("end_exp_rx_empty", exp_rx.size(), 32'd0);
        chk("end_exp_miso_empty", exp_miso.size(), 32'd0);
        chk("end_act_miso_empty", act_miso.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
